// File: rtl/ir_pkg.sv
// Shared IR display helpers: hex-to-segment encoding, digit enables and 50 MHz timing defaults.
package ir_pkg;

  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int HOLDOFF_CYC_DEF = 5_000_000;
  localparam int SCAN_DIV_DEF    = 50_000;

  localparam logic [3:0] DIGIT_EN0 = 4'he;
  localparam logic [3:0] DIGIT_EN1 = 4'hd;
  localparam logic [3:0] DIGIT_EN2 = 4'hb;
  localparam logic [3:0] DIGIT_EN3 = 4'h7;

  localparam logic [7:0] SEG_F     = 8'h8e;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [1:0] {DIG_LO, DIG_HI, DIG_CNT, DIG_FLAG} digit_e;

  // Segment order is a..g in bits 7..1, dp in bit 0, active-high.
  function automatic logic [7:0] hex7seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hfc;
      4'h1: s = 8'h60;
      4'h2: s = 8'hda;
      4'h3: s = 8'hf2;
      4'h4: s = 8'h66;
      4'h5: s = 8'hb6;
      4'h6: s = 8'hbe;
      4'h7: s = 8'he0;
      4'h8: s = 8'hfe;
      4'h9: s = 8'he6;
      4'ha: s = 8'hee;
      4'hb: s = 8'h3e;
      4'hc: s = 8'h9c;
      4'hd: s = 8'h7a;
      4'he: s = 8'h9e;
      default: s = 8'h8e;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; the head entry is presented combinationally and reads as zero when empty.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_i);
    rd_ptr_d = rd_ptr_q + AW'(pop_i);
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: empty gating hides stale entries.
  always_ff @(posedge clk) begin
    if (!rstb && push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ir_cmd_scheduler.sv
// IR command scheduler: drops auto-repeats of a held key, queues accepted codes for a
// valid/ready consumer and scans the last dispatched code and queue state onto 4 digits.
module ir_cmd_scheduler import ir_pkg::*; #(
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int HOLDOFF_CYC = HOLDOFF_CYC_DEF,
  parameter int SCAN_DIV    = SCAN_DIV_DEF
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       overflow,
  output logic [7:0] SEG,
  output logic [3:0] DIGIT
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int HW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYC - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [7:0]    last_code_q, last_code_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    shown_q, shown_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  digit_e        digit_idx_q, digit_idx_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    digit_q, digit_d;

  logic          suppress, push_req, push, pop;
  logic [7:0]    fifo_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  // A full queue still takes a new code when the head leaves in the same cycle.
  assign suppress = cmd_valid && (cmd_data == last_code_q) && (hold_cnt_q != '0);
  assign push_req = cmd_valid && !suppress;
  assign pop      = !fifo_empty && out_ready;
  assign push     = push_req && (!fifo_full || pop);

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rstb    (rstb),
    .push_i  (push),
    .data_i  (cmd_data),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    last_code_d = last_code_q;
    hold_cnt_d  = hold_cnt_q;
    if (cmd_valid) begin
      last_code_d = cmd_data;
      hold_cnt_d  = HOLD_LOAD;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HW'(1);
    end
    overflow_d = overflow_q | (push_req && !push);
    shown_d    = pop ? fifo_data : shown_q;
  end

  // SEG/DIGIT are recomputed only on a scan tick, for the digit being advanced to.
  always_comb begin
    scan_cnt_d  = scan_cnt_q + SW'(1);
    digit_idx_d = digit_idx_q;
    seg_d       = seg_q;
    digit_d     = digit_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d  = '0;
      digit_idx_d = digit_e'(digit_idx_q + 2'd1);
      case (digit_idx_d)
        DIG_LO: begin
          digit_d = DIGIT_EN0;
          seg_d   = hex7seg(shown_q[3:0]);
        end
        DIG_HI: begin
          digit_d = DIGIT_EN1;
          seg_d   = hex7seg(shown_q[7:4]);
        end
        DIG_CNT: begin
          digit_d = DIGIT_EN2;
          seg_d   = hex7seg(4'(fifo_count));
        end
        DIG_FLAG: begin
          digit_d = DIGIT_EN3;
          seg_d   = overflow_q ? SEG_F : SEG_BLANK;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      last_code_q <= '0;
      hold_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      shown_q     <= '0;
      scan_cnt_q  <= '0;
      digit_idx_q <= DIG_LO;
      seg_q       <= hex7seg(4'h0);
      digit_q     <= DIGIT_EN0;
    end else begin
      last_code_q <= last_code_d;
      hold_cnt_q  <= hold_cnt_d;
      overflow_q  <= overflow_d;
      shown_q     <= shown_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      seg_q       <= seg_d;
      digit_q     <= digit_d;
    end
  end

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_data;
  assign overflow  = overflow_q;
  assign SEG       = seg_q;
  assign DIGIT     = digit_q;

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Directed bench for ir_cmd_scheduler: vector table for queue behaviour plus hand sequences
// for the display scan and the repeat-suppression window.
module tb_ir_cmd_scheduler;

  localparam int DEPTH   = 4;
  localparam int HOLDOFF = 5000;
  localparam int SCAN    = 10;

  logic       clk;
  logic       rstb;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       overflow;
  logic [7:0] SEG;
  logic [3:0] DIGIT;

  int checks;
  int errors;
  int validSeen;

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       expV;
    logic [7:0] expD;
    logic       expOvf;
  } vec_t;

  vec_t vecs [28];

  ir_cmd_scheduler #(
    .FIFO_DEPTH  (DEPTH),
    .HOLDOFF_CYC (HOLDOFF),
    .SCAN_DIV    (SCAN)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .overflow  (overflow),
    .SEG       (SEG),
    .DIGIT     (DIGIT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic v, input logic [7:0] d,
                              input logic rdy, input logic eV, input logic [7:0] eD,
                              input logic eO);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.rdy = rdy;
    r.expV = eV; r.expD = eD; r.expOvf = eO;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (out_valid) validSeen++;
  endtask

  task automatic checkOutput(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Inputs are held for exactly one rising edge, then outputs are compared.
  task automatic applyStimulus(input int i);
    rstb      = vecs[i].rst;
    cmd_valid = vecs[i].v;
    cmd_data  = vecs[i].d;
    out_ready = vecs[i].rdy;
    tick();
    rstb      = 1'b0;
    cmd_valid = 1'b0;
    checkOutput($sformatf("row%0d out_valid", i), 8'(out_valid), 8'(vecs[i].expV));
    checkOutput($sformatf("row%0d out_data", i), out_data, vecs[i].expD);
    checkOutput($sformatf("row%0d overflow", i), 8'(overflow), 8'(vecs[i].expOvf));
  endtask

  task automatic runRows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) applyStimulus(i);
  endtask

  // Waits for a fresh arrival on the given digit so a stale pattern is never sampled.
  task automatic waitDigit(input logic [3:0] dg, input logic [7:0] sg, input string nm);
    bit armed;
    int n;
    armed = (DIGIT != dg);
    n = 0;
    while (!(armed && DIGIT == dg) && n < 5 * SCAN) begin
      tick();
      if (DIGIT != dg) armed = 1'b1;
      n++;
    end
    if (armed && DIGIT == dg) begin
      checkOutput(nm, SEG, sg);
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: digit %h never reached, DIGIT=%h", nm, dg, DIGIT);
    end
  endtask

  task automatic pulseCmd(input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    checks = 0; errors = 0; validSeen = 0;

    vecs[0]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 0);
    vecs[1]  = mk(0, 1, 8'h01, 0, 1, 8'h01, 0);
    vecs[2]  = mk(0, 1, 8'h02, 0, 1, 8'h01, 0);
    vecs[3]  = mk(0, 1, 8'h03, 0, 1, 8'h01, 0);
    vecs[4]  = mk(0, 1, 8'h04, 0, 1, 8'h01, 0);
    vecs[5]  = mk(0, 1, 8'h05, 0, 1, 8'h01, 1);
    vecs[6]  = mk(0, 0, 8'h00, 1, 1, 8'h02, 1);
    vecs[7]  = mk(0, 0, 8'h00, 1, 1, 8'h03, 1);
    vecs[8]  = mk(0, 0, 8'h00, 1, 1, 8'h04, 1);
    vecs[9]  = mk(0, 0, 8'h00, 1, 0, 8'h00, 1);
    vecs[10] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0);
    vecs[11] = mk(0, 1, 8'h11, 0, 1, 8'h11, 0);
    vecs[12] = mk(0, 1, 8'h12, 0, 1, 8'h11, 0);
    vecs[13] = mk(0, 1, 8'h13, 0, 1, 8'h11, 0);
    vecs[14] = mk(0, 1, 8'h14, 0, 1, 8'h11, 0);
    vecs[15] = mk(0, 1, 8'h09, 1, 1, 8'h12, 0);
    vecs[16] = mk(0, 0, 8'h00, 0, 1, 8'h12, 0);
    vecs[17] = mk(0, 0, 8'h00, 1, 1, 8'h13, 0);
    vecs[18] = mk(0, 0, 8'h00, 1, 1, 8'h14, 0);
    vecs[19] = mk(0, 0, 8'h00, 1, 1, 8'h09, 0);
    vecs[20] = mk(0, 0, 8'h00, 1, 0, 8'h00, 0);
    vecs[21] = mk(0, 1, 8'h21, 0, 1, 8'h21, 0);
    vecs[22] = mk(0, 1, 8'h22, 0, 1, 8'h21, 0);
    vecs[23] = mk(0, 1, 8'h23, 0, 1, 8'h21, 0);
    vecs[24] = mk(1, 0, 8'h00, 1, 0, 8'h00, 0);
    vecs[25] = mk(0, 0, 8'h00, 1, 0, 8'h00, 0);
    vecs[26] = mk(0, 1, 8'h45, 1, 1, 8'h45, 0);
    vecs[27] = mk(0, 0, 8'h00, 1, 0, 8'h00, 0);

    rstb = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00; out_ready = 1'b0;
    tick();
    tick();
    checkOutput("reset out_valid", 8'(out_valid), 8'h00);
    checkOutput("reset out_data", out_data, 8'h00);
    checkOutput("reset overflow", 8'(overflow), 8'h00);
    checkOutput("reset DIGIT", 8'(DIGIT), 8'h0e);
    checkOutput("reset SEG", SEG, 8'hfc);
    rstb = 1'b0;

    waitDigit(4'hd, 8'hfc, "idle digit1");
    waitDigit(4'hb, 8'hfc, "idle digit2");
    waitDigit(4'h7, 8'h00, "idle digit3");
    waitDigit(4'he, 8'hfc, "idle digit0");
    checkOutput("idle out_valid", 8'(out_valid), 8'h00);

    runRows(0, 5);
    waitDigit(4'h7, 8'h8e, "overflow flag digit");
    waitDigit(4'hb, 8'h66, "count full digit");
    runRows(6, 9);
    waitDigit(4'hb, 8'hfc, "count drained digit");
    runRows(10, 16);
    waitDigit(4'hb, 8'h66, "count after full swap");
    waitDigit(4'h7, 8'h00, "no overflow after swap");
    runRows(17, 25);
    waitDigit(4'he, 8'hfc, "shown cleared by reset");
    runRows(26, 27);
    waitDigit(4'h7, 8'h00, "flag after 45");
    waitDigit(4'he, 8'hb6, "shown low nibble 5");
    waitDigit(4'hd, 8'h66, "shown high nibble 4");
    waitDigit(4'hb, 8'hfc, "count empty after 45");

    out_ready = 1'b1;
    validSeen = 0;
    pulseCmd(8'h16);
    checkOutput("first 16 valid", 8'(out_valid), 8'h01);
    checkOutput("first 16 data", out_data, 8'h16);
    idle(999);
    pulseCmd(8'h16);
    idle(999);
    pulseCmd(8'h16);
    idle(20);
    checkOutput("held key dispatches", 8'(validSeen), 8'd1);
    idle(HOLDOFF - 1 - 21);
    pulseCmd(8'h16);
    idle(20);
    checkOutput("repeat at holdoff-1 suppressed", 8'(validSeen), 8'd1);
    idle(HOLDOFF - 21);
    pulseCmd(8'h16);
    checkOutput("repeat at holdoff valid", 8'(out_valid), 8'h01);
    checkOutput("repeat at holdoff data", out_data, 8'h16);
    idle(5);
    checkOutput("dispatches after holdoff", 8'(validSeen), 8'd2);
    checkOutput("no overflow after suppress", 8'(overflow), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
